drive_arbiter: RTL and testbench

Arbitrates motor and steering commands between the keyboard path (manual) and an autonomous sequencer (auto), with emergency-stop override. Sequences the motor PWM duty through soft-start and soft-stop ramps and never reverses while duty is non-zero. Sits between the keyboard decoder / sequencer outputs and the motor and servo PWM generators. Ramp pacing comes from a one-cycle `tick` strobe generated from the divided control clock.

---
 rtl/drive_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_drive_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/drive_arbiter.sv
// drive_arbiter: chooses between the manual and autonomous command paths,
// ramps the motor duty up and down on tick strobes, and forces an
// emergency stop that is held until stop has been low for HOLD_TICKS ticks.
// Direction is only reloaded from IDLE, where duty is always zero.
module drive_arbiter #(
  parameter logic [7:0]  DUTY_MAX   = 8'd200,
  parameter logic [7:0]  RAMP_STEP  = 8'd4,
  parameter logic [15:0] HOLD_TICKS = 16'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       stop,
  input  logic [1:0] man_drive,
  input  logic [1:0] man_direc,
  input  logic       auto_req,
  input  logic [1:0] auto_drive,
  input  logic [1:0] auto_direc,
  output logic       auto_gnt,
  output logic [7:0] duty,
  output logic       dir_rev,
  output logic [1:0] steer,
  output logic [2:0] state,
  output logic       estop
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RAMP_UP = 3'd1,
    S_RUN     = 3'd2,
    S_RAMP_DN = 3'd3,
    S_ESTOP   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  duty_reg, duty_next;
  logic        dir_rev_reg, dir_rev_next;
  logic [1:0]  steer_reg, steer_next;
  logic        auto_gnt_reg, auto_gnt_next;
  logic        estop_reg, estop_next;
  logic [15:0] hold_cnt_reg, hold_cnt_next;

  logic        man_act;
  logic [1:0]  cmd_drive;
  logic [1:0]  cmd_direc;
  logic        cmd_act;
  logic        cmd_rev;
  logic        cmd_match;
  logic [8:0]  duty_up_wide;
  logic [7:0]  duty_up;
  logic [7:0]  duty_dn;
  logic [15:0] hold_inc;

  // Command selection: manual preempts auto combinationally in the same cycle.
  always_comb begin
    man_act   = (man_drive == 2'b01) || (man_drive == 2'b10);
    cmd_drive = 2'b00;
    cmd_direc = 2'b00;
    if (man_act) begin
      cmd_drive = man_drive;
      cmd_direc = man_direc;
    end else if (auto_gnt_reg) begin
      cmd_drive = auto_drive;
      cmd_direc = auto_direc;
    end
    cmd_act   = (cmd_drive == 2'b01) || (cmd_drive == 2'b10);
    cmd_rev   = (cmd_drive == 2'b10);
    cmd_match = cmd_act && (cmd_rev == dir_rev_reg);
  end

  // Ramp arithmetic; the up step is done at 9 bits so it saturates instead of wrapping.
  always_comb begin
    duty_up_wide = {1'b0, duty_reg} + {1'b0, RAMP_STEP};
    duty_up      = (duty_up_wide > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_up_wide[7:0];
    duty_dn      = (duty_reg > RAMP_STEP) ? (duty_reg - RAMP_STEP) : 8'd0;
    hold_inc     = hold_cnt_reg + 16'd1;
  end

  // Next-state and next-output logic; a taken transition never steps duty.
  always_comb begin
    state_next    = state_reg;
    duty_next     = duty_reg;
    dir_rev_next  = dir_rev_reg;
    hold_cnt_next = hold_cnt_reg;

    if (stop) begin
      state_next    = S_ESTOP;
      duty_next     = 8'd0;
      hold_cnt_next = 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          duty_next = 8'd0;
          if (cmd_act) begin
            dir_rev_next = cmd_rev;
            state_next   = S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (!cmd_match) begin
            state_next = S_RAMP_DN;
          end else if (duty_reg == DUTY_MAX) begin
            state_next = S_RUN;
          end else if (tick) begin
            duty_next = duty_up;
          end
        end
        S_RUN: begin
          duty_next = DUTY_MAX;
          if (!cmd_match) begin
            state_next = S_RAMP_DN;
          end
        end
        S_RAMP_DN: begin
          if (cmd_match) begin
            state_next = S_RAMP_UP;
          end else if (duty_reg == 8'd0) begin
            state_next = S_IDLE;
          end else if (tick) begin
            duty_next = duty_dn;
          end
        end
        S_ESTOP: begin
          duty_next = 8'd0;
          if (tick) begin
            hold_cnt_next = hold_inc;
            if (hold_inc == HOLD_TICKS) begin
              state_next = S_IDLE;
            end
          end
        end
        default: begin
          state_next = S_IDLE;
          duty_next  = 8'd0;
        end
      endcase
    end
  end

  // Registered side outputs: grant, steering (11 folded to straight) and estop flag.
  always_comb begin
    auto_gnt_next = auto_req && !man_act && !stop && (state_reg != S_ESTOP);
    if (state_next == S_ESTOP) begin
      steer_next = 2'b00;
    end else if (cmd_direc == 2'b11) begin
      steer_next = 2'b00;
    end else begin
      steer_next = cmd_direc;
    end
    estop_next = (state_next == S_ESTOP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      duty_reg     <= 8'd0;
      dir_rev_reg  <= 1'b0;
      steer_reg    <= 2'b00;
      auto_gnt_reg <= 1'b0;
      estop_reg    <= 1'b0;
      hold_cnt_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      duty_reg     <= duty_next;
      dir_rev_reg  <= dir_rev_next;
      steer_reg    <= steer_next;
      auto_gnt_reg <= auto_gnt_next;
      estop_reg    <= estop_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign state    = state_reg;
  assign duty     = duty_reg;
  assign dir_rev  = dir_rev_reg;
  assign steer    = steer_reg;
  assign auto_gnt = auto_gnt_reg;
  assign estop    = estop_reg;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter: one default-parameter instance (a) and a
// small instance (b: DUTY_MAX=10, RAMP_STEP=4, HOLD_TICKS=3) sharing inputs.
module tb_drive_arbiter;

  logic       clk = 1'b0;
  logic       rst, tick, stop, auto_req;
  logic [1:0] man_drive, man_direc, auto_drive, auto_direc;

  logic       gnt_a, dir_a, estop_a;
  logic [7:0] duty_a;
  logic [1:0] steer_a;
  logic [2:0] state_a;
  logic       gnt_b, dir_b, estop_b;
  logic [7:0] duty_b;
  logic [1:0] steer_b;
  logic [2:0] state_b;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  drive_arbiter dut_a (
    .clk(clk), .rst(rst), .tick(tick), .stop(stop),
    .man_drive(man_drive), .man_direc(man_direc),
    .auto_req(auto_req), .auto_drive(auto_drive), .auto_direc(auto_direc),
    .auto_gnt(gnt_a), .duty(duty_a), .dir_rev(dir_a), .steer(steer_a),
    .state(state_a), .estop(estop_a)
  );

  drive_arbiter #(.DUTY_MAX(8'd10), .RAMP_STEP(8'd4), .HOLD_TICKS(16'd3)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .stop(stop),
    .man_drive(man_drive), .man_direc(man_direc),
    .auto_req(auto_req), .auto_drive(auto_drive), .auto_direc(auto_direc),
    .auto_gnt(gnt_b), .duty(duty_b), .dir_rev(dir_b), .steer(steer_b),
    .state(state_b), .estop(estop_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 1'b0; stop = 1'b0; auto_req = 1'b0;
    man_drive = 2'b00; man_direc = 2'b00; auto_drive = 2'b00; auto_direc = 2'b00;
    step(); step();
    rst = 1'b0;
    vectors++; if (state_a !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_a); end
    vectors++; if (duty_a !== 8'd0) begin fails++; $display("FAIL reset_duty: got %0d want 0", duty_a); end
    vectors++; if (dir_a !== 1'b0) begin fails++; $display("FAIL reset_dir: got %0b want 0", dir_a); end
    vectors++; if (steer_a !== 2'b00) begin fails++; $display("FAIL reset_steer: got %0b want 00", steer_a); end
    vectors++; if (gnt_a !== 1'b0 || estop_a !== 1'b0) begin fails++; $display("FAIL reset_gnt_estop: got %0b%0b want 00", gnt_a, estop_a); end
    vectors++; if (state_b !== 3'd0 || duty_b !== 8'd0) begin fails++; $display("FAIL reset_b: got state %0d duty %0d want 0 0", state_b, duty_b); end
    $display("test_reset done");
  endtask

  task automatic test_forward_ramp;
    man_drive = 2'b01; man_direc = 2'b01;
    step();
    vectors++; if (state_a !== 3'd1) begin fails++; $display("FAIL fwd_start_state: got %0d want 1", state_a); end
    vectors++; if (steer_a !== 2'b01) begin fails++; $display("FAIL fwd_steer: got %0b want 01", steer_a); end
    vectors++; if (dir_a !== 1'b0) begin fails++; $display("FAIL fwd_dir: got %0b want 0", dir_a); end
    for (int i = 1; i <= 50; i++) begin
      pulse_tick();
      vectors++; if (duty_a !== 8'(4 * i) || state_a !== 3'd1) begin fails++; $display("FAIL fwd_ramp tick %0d: got duty %0d state %0d want %0d 1", i, duty_a, state_a, 4 * i); end
      if (i <= 3) begin
        vectors++; if (duty_b !== ((i == 3) ? 8'd10 : 8'(4 * i))) begin fails++; $display("FAIL b_up tick %0d: got %0d", i, duty_b); end
      end
      step();
      if (i == 4) begin
        vectors++; if (state_b !== 3'd2) begin fails++; $display("FAIL b_run: got %0d want 2", state_b); end
      end
      if (i == 50) begin
        vectors++; if (state_a !== 3'd2 || duty_a !== 8'd200) begin fails++; $display("FAIL fwd_run: got state %0d duty %0d want 2 200", state_a, duty_a); end
      end
      step(); step();
    end
    man_direc = 2'b11;
    step();
    vectors++; if (steer_a !== 2'b00) begin fails++; $display("FAIL steer_norm: got %0b want 00", steer_a); end
    man_direc = 2'b01;
    step();
    $display("test_forward_ramp done");
  endtask

  task automatic test_reversal;
    man_drive = 2'b10;
    step();
    vectors++; if (state_a !== 3'd3 || duty_a !== 8'd200) begin fails++; $display("FAIL rev_enter: got state %0d duty %0d want 3 200", state_a, duty_a); end
    vectors++; if (state_b !== 3'd3 || duty_b !== 8'd10) begin fails++; $display("FAIL b_rev_enter: got state %0d duty %0d want 3 10", state_b, duty_b); end
    for (int i = 1; i <= 50; i++) begin
      pulse_tick();
      vectors++; if (duty_a !== 8'(200 - 4 * i) || dir_a !== 1'b0 || state_a !== 3'd3) begin fails++; $display("FAIL rev_ramp tick %0d: got duty %0d dir %0b state %0d want %0d 0 3", i, duty_a, dir_a, state_a, 200 - 4 * i); end
      if (i <= 3) begin
        vectors++; if (duty_b !== ((i == 1) ? 8'd6 : (i == 2) ? 8'd2 : 8'd0)) begin fails++; $display("FAIL b_down tick %0d: got %0d", i, duty_b); end
      end
      step();
      if (i == 50) begin
        vectors++; if (state_a !== 3'd0 || dir_a !== 1'b0 || duty_a !== 8'd0) begin fails++; $display("FAIL rev_idle: got state %0d dir %0b duty %0d want 0 0 0", state_a, dir_a, duty_a); end
      end
      step();
      if (i == 50) begin
        vectors++; if (state_a !== 3'd1 || dir_a !== 1'b1) begin fails++; $display("FAIL rev_restart: got state %0d dir %0b want 1 1", state_a, dir_a); end
      end
      step();
    end
    for (int i = 1; i <= 25; i++) pulse_tick();
    vectors++; if (duty_a !== 8'd100 || dir_a !== 1'b1) begin fails++; $display("FAIL rev_up100: got duty %0d dir %0b want 100 1", duty_a, dir_a); end
    $display("test_reversal done");
  endtask

  task automatic test_estop;
    stop = 1'b1;
    step();
    vectors++; if (state_a !== 3'd4 || duty_a !== 8'd0 || estop_a !== 1'b1) begin fails++; $display("FAIL estop_enter: got state %0d duty %0d estop %0b want 4 0 1", state_a, duty_a, estop_a); end
    vectors++; if (steer_a !== 2'b00 || gnt_a !== 1'b0) begin fails++; $display("FAIL estop_steer: got steer %0b gnt %0b want 00 0", steer_a, gnt_a); end
    pulse_tick();
    stop = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      vectors++; if (state_b !== ((i == 3) ? 3'd0 : 3'd4)) begin fails++; $display("FAIL b_hold tick %0d: got state %0d", i, state_b); end
      step();
    end
    vectors++; if (state_b !== 3'd1 || dir_b !== 1'b1) begin fails++; $display("FAIL b_exit_act: got state %0d dir %0b want 1 1", state_b, dir_b); end
    vectors++; if (state_a !== 3'd4 || duty_a !== 8'd0) begin fails++; $display("FAIL a_still_estop: got state %0d duty %0d want 4 0", state_a, duty_a); end
    man_drive = 2'b00;
    for (int i = 4; i <= 50; i++) begin
      pulse_tick();
      vectors++; if (state_a !== ((i == 50) ? 3'd0 : 3'd4) || estop_a !== (i != 50)) begin fails++; $display("FAIL a_hold tick %0d: got state %0d estop %0b", i, state_a, estop_a); end
    end
    $display("test_estop done");
  endtask

  task automatic test_arbitration;
    auto_req = 1'b1; auto_drive = 2'b01; auto_direc = 2'b10;
    step();
    vectors++; if (gnt_a !== 1'b1 || state_a !== 3'd0 || steer_a !== 2'b00) begin fails++; $display("FAIL arb_grant: got gnt %0b state %0d steer %0b want 1 0 00", gnt_a, state_a, steer_a); end
    step();
    vectors++; if (state_a !== 3'd1 || dir_a !== 1'b0 || steer_a !== 2'b10) begin fails++; $display("FAIL arb_auto_up: got state %0d dir %0b steer %0b want 1 0 10", state_a, dir_a, steer_a); end
    for (int i = 1; i <= 5; i++) pulse_tick();
    vectors++; if (duty_a !== 8'd20) begin fails++; $display("FAIL arb_duty20: got %0d want 20", duty_a); end
    man_drive = 2'b10;
    step();
    vectors++; if (gnt_a !== 1'b0 || state_a !== 3'd3 || duty_a !== 8'd20 || steer_a !== 2'b01) begin fails++; $display("FAIL arb_preempt: got gnt %0b state %0d duty %0d steer %0b want 0 3 20 01", gnt_a, state_a, duty_a, steer_a); end
    for (int i = 1; i <= 5; i++) begin
      pulse_tick();
      vectors++; if (duty_a !== 8'(20 - 4 * i) || dir_a !== 1'b0) begin fails++; $display("FAIL arb_down tick %0d: got duty %0d dir %0b", i, duty_a, dir_a); end
    end
    step();
    vectors++; if (state_a !== 3'd0 || dir_a !== 1'b0) begin fails++; $display("FAIL arb_idle: got state %0d dir %0b want 0 0", state_a, dir_a); end
    step();
    vectors++; if (state_a !== 3'd1 || dir_a !== 1'b1 || gnt_a !== 1'b0) begin fails++; $display("FAIL arb_rev_up: got state %0d dir %0b gnt %0b want 1 1 0", state_a, dir_a, gnt_a); end
    $display("test_arbitration done");
  endtask

  task automatic test_mid_reset;
    auto_req = 1'b0;
    for (int i = 1; i <= 15; i++) pulse_tick();
    man_drive = 2'b00;
    step();
    vectors++; if (state_a !== 3'd3 || duty_a !== 8'd60) begin fails++; $display("FAIL mr_setup: got state %0d duty %0d want 3 60", state_a, duty_a); end
    rst = 1'b1; tick = 1'b1;
    step();
    rst = 1'b0; tick = 1'b0;
    vectors++; if (state_a !== 3'd0 || duty_a !== 8'd0 || dir_a !== 1'b0 || steer_a !== 2'b00 || gnt_a !== 1'b0 || estop_a !== 1'b0) begin fails++; $display("FAIL mid_reset: got state %0d duty %0d dir %0b steer %0b gnt %0b estop %0b want all 0", state_a, duty_a, dir_a, steer_a, gnt_a, estop_a); end
    $display("test_mid_reset done");
  endtask

  task automatic test_random_dir;
    logic       prev_dir;
    logic [7:0] prev_duty;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) man_drive = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) auto_drive = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) auto_req = ~auto_req;
      man_direc = 2'($urandom_range(0, 3));
      auto_direc = 2'($urandom_range(0, 3));
      stop = ($urandom_range(0, 255) == 0);
      tick = ($urandom_range(0, 1) == 0);
      prev_dir = dir_a; prev_duty = duty_a;
      step();
      vectors++; if (dir_a !== prev_dir && prev_duty !== 8'd0) begin fails++; $display("FAIL rand_dir cycle %0d: dir %0b->%0b with duty %0d", c, prev_dir, dir_a, prev_duty); end
      vectors++; if (duty_a > 8'd200 || steer_a === 2'b11) begin fails++; $display("FAIL rand_bounds cycle %0d: duty %0d steer %0b", c, duty_a, steer_a); end
    end
    stop = 1'b0; tick = 1'b0;
    $display("test_random_dir done");
  endtask

  initial begin
    test_reset();
    test_forward_ramp();
    test_reversal();
    test_estop();
    test_arbitration();
    test_mid_reset();
    test_random_dir();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
